// File: rtl/cnt_cmd_sched.sv
// Merges button and UART commands into a run/stop/clear sequence and queues UART acknowledgements.
// Latency: a request sampled at one edge shows up on the outputs right after that edge; an ack appears 1 cycle after rx_valid.
// Backpressure: one-entry tx slot; an ack that finds the slot full and not draining is dropped and o_drop pulses.
module cnt_cmd_sched #(
  parameter int CLR_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_clr,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       o_run_on,
  output logic       o_clr_on,
  output logic       o_drop
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLR_CYCLES - 1);

  localparam logic [7:0] CH_R_UP = 8'h52;
  localparam logic [7:0] CH_C_UP = 8'h43;
  localparam logic [7:0] CH_S_UP = 8'h53;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] ACK_R   = 8'h72;
  localparam logic [7:0] ACK_S   = 8'h73;
  localparam logic [7:0] ACK_C   = 8'h63;
  localparam logic [7:0] ACK_BAD = 8'h3F;
  localparam logic [7:0] ACK_ARB = 8'h42;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       rx_up;
  logic             uart_r, uart_c, uart_s, uart_eol;
  logic             btn_req;
  logic             ack_vld;
  logic [7:0]       ack_byte;
  logic [7:0]       state_chr;

  // Fold lowercase letters onto uppercase so decode is case-insensitive.
  always_comb begin
    rx_up = rx_data;
    if (rx_data >= 8'h61 && rx_data <= 8'h7A) begin
      rx_up = rx_data - 8'h20;
    end
  end

  assign uart_r   = rx_valid && (rx_up == CH_R_UP);
  assign uart_c   = rx_valid && (rx_up == CH_C_UP);
  assign uart_s   = rx_valid && (rx_up == CH_S_UP);
  assign uart_eol = (rx_data == CH_CR) || (rx_data == CH_LF);

  // A button request, when present, beats any UART run/clear command in the same cycle.
  assign btn_req = btn_run || (btn_clr && (state == ST_STOP));

  // Next-state, clear-duration counter and acknowledgement selection.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ack_vld   = 1'b0;
    ack_byte  = 8'h00;
    state_chr = ACK_S;

    case (state)
      ST_STOP: begin
        if (btn_run) begin
          state_n = ST_RUN;
        end else if (btn_clr) begin
          state_n = ST_CLEAR;
          cnt_n   = CLR_LOAD;
        end else if (uart_r) begin
          state_n = ST_RUN;
        end else if (uart_c) begin
          state_n = ST_CLEAR;
          cnt_n   = CLR_LOAD;
        end
      end
      ST_RUN: begin
        state_chr = ACK_R;
        if (btn_run || uart_r) begin
          state_n = ST_STOP;
        end
      end
      ST_CLEAR: begin
        state_chr = ACK_C;
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (!btn_clr) begin
          state_n = ST_STOP;
        end
      end
      default: begin
        state_n = ST_STOP;
        cnt_n   = '0;
      end
    endcase

    if (uart_r || uart_c) begin
      ack_vld = 1'b1;
      if (btn_req) begin
        ack_byte = ACK_ARB;
      end else if (uart_r && state != ST_CLEAR) begin
        ack_byte = (state_n == ST_RUN) ? ACK_R : ACK_S;
      end else if (uart_c && state == ST_STOP) begin
        ack_byte = ACK_C;
      end else begin
        ack_byte = ACK_BAD;
      end
    end else if (uart_s) begin
      ack_vld  = 1'b1;
      ack_byte = state_chr;
    end else if (rx_valid && !uart_eol) begin
      ack_vld  = 1'b1;
      ack_byte = ACK_BAD;
    end
  end

  // State register, clear counter and the one-entry acknowledgement slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_STOP;
      cnt      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      o_drop   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      o_drop <= 1'b0;
      if (ack_vld) begin
        if (!tx_valid || tx_ready) begin
          tx_valid <= 1'b1;
          tx_data  <= ack_byte;
        end else begin
          o_drop <= 1'b1;
        end
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

  assign o_run_on = (state == ST_RUN);
  assign o_clr_on = (state == ST_CLEAR);

endmodule
